bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of bits per word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
REQ-003 Parameter IDLE_BIT, default 0, is the value driven on out when no word is being sent.
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 R  input  1  Asynchronous active-high reset.
REQ-006 data_in  input  WIDTH  Parallel word to serialize.
REQ-007 load_valid  input  1  data_in is valid this cycle.
REQ-008 load_ready  output  1  The block can accept a word this cycle.
REQ-009 out  output  1  Serial bit stream; feeds the 1-bit input of the downstream sequence detector.
REQ-010 out_valid  output  1  out carries a data bit this cycle.
REQ-011 frame_last  output  1  out carries the final bit of the current word.

Function
REQ-012 A word is accepted on a rising edge where load_valid=1 and load_ready=1; no other edge accepts a word.
REQ-013 The block SHALL hold a WIDTH-bit shift register, a bit counter of ceil(log2(WIDTH)) bits, a one-word pending buffer with a full flag, and a two-state FSM (IDLE, SHIFT).
REQ-014 load_ready = (not R) AND (pending buffer empty); it is combinational from registered state only and never depends on load_valid.
REQ-015 IDLE with an accept: load the shift register from data_in, clear the counter, and go to SHIFT at the same edge; the first bit is valid on out in the cycle immediately following that edge.
REQ-016 SHIFT with an accept while the pending buffer is empty and the counter is not WIDTH-1: store the word in the pending buffer and set the full flag.
REQ-017 Each SHIFT edge with counter < WIDTH-1 advances one bit (shift toward the output end) and increments the counter; each bit is held on out for exactly one clock.
REQ-018 Edge at counter = WIDTH-1, with the pending buffer full: load the pending word, clear the full flag, clear the counter, and stay in SHIFT (no gap bit).
REQ-019 Edge at counter = WIDTH-1, with the buffer empty and an accept on the same edge: load data_in directly (bypass) and stay in SHIFT (no gap bit).
REQ-020 Edge at counter = WIDTH-1, with the buffer empty and no accept: go to IDLE.
REQ-021 out = selected end bit of the shift register when in SHIFT, else IDLE_BIT.
REQ-022 out_valid = 1 only in SHIFT.
REQ-023 frame_last = 1 only when in SHIFT and the counter = WIDTH-1.
REQ-024 All outputs are glitch-free functions of registered state, except load_ready, which is also gated by R.
REQ-025 Sustained load_valid produces a continuous stream with out_valid held at 1 and one frame_last every WIDTH cycles.
REQ-026 data_in is sampled only at the accepting edge; later changes to data_in do not affect a word already in flight.

Reset
REQ-027 R=1 SHALL immediately and asynchronously clear the following, regardless of clock:
- FSM to IDLE, counter to 0, shift register to 0, pending full flag to 0;
- out=IDLE_BIT, out_valid=0, frame_last=0, load_ready=0.
REQ-028 Reset mid-word discards both the in-flight word and the pending word; no partial bits are emitted after R deasserts.
REQ-029 After R falls, load_ready=1 in the same cycle; the first accept starts a new word at bit 0.

Verification
REQ-030 Reset: hold R=1 for 2 clocks, then release.
- During reset: out=0, out_valid=0, load_ready=0.
- After release: load_ready=1, out_valid=0.
REQ-031 Single word, WIDTH=8, MSB_FIRST=1: accept 8'b1011_0101.
- out = 1,0,1,1,0,1,0,1 on 8 consecutive cycles, out_valid=1 throughout, frame_last on the 8th cycle only.
- out_valid=0 and out=0 on the 9th cycle.
REQ-032 Back-to-back: load_valid held at 1 with 8'hA5, then 8'h0F.
- 16 contiguous valid bits, 1010_0101_0000_1111.
- load_ready=0 while the pending buffer is full.
- frame_last on cycles 8 and 16.
REQ-033 Bypass: present a second word exactly on the frame_last cycle of the first, with the buffer empty -> no gap bit between the words.
REQ-034 Reset mid-word: assert R after 3 bits of 8'hFF.
- out=0 immediately; the pending 8'h33 is lost.
- The next accepted 8'h80 emits 1 followed by seven 0s.
REQ-035 MSB_FIRST=0, accept 8'h01 -> out = 1 then seven 0s.
REQ-036 Integration: serialize 8'b0010_1010 into the downstream 101 detector -> detector output pulses on the 5th and 7th bits.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word pending buffer so that a
// continuously offered stream of words leaves the block with no idle bits.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_last
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] pend_r;
    logic             pend_full_r;
    logic             out_r;
    logic             out_valid_r;
    logic             frame_last_r;
    logic             accept_s;

    // Moves the next bit to the output end of the shift register.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    // Bit presented on out for a given shift-register content.
    function automatic logic end_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // Ready depends only on the buffer flag and reset, never on load_valid.
    assign load_ready = ~R & ~pend_full_r;
    assign accept_s   = load_valid & load_ready;

    assign out        = out_r;
    assign out_valid  = out_valid_r;
    assign frame_last = frame_last_r;

    // Serializer FSM; outputs are registered alongside the state they describe.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {WIDTH{1'b0}};
            cnt_r        <= CNT_ZERO;
            pend_r       <= {WIDTH{1'b0}};
            pend_full_r  <= 1'b0;
            out_r        <= IDLE_BIT;
            out_valid_r  <= 1'b0;
            frame_last_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_r      <= data_in;
                        cnt_r        <= CNT_ZERO;
                        state_r      <= ST_SHIFT;
                        out_r        <= end_bit(data_in);
                        out_valid_r  <= 1'b1;
                        frame_last_r <= 1'b0;
                    end else begin
                        out_r        <= IDLE_BIT;
                        out_valid_r  <= 1'b0;
                        frame_last_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r != CNT_LAST) begin
                        shreg_r      <= shift_word(shreg_r);
                        cnt_r        <= cnt_r + CNT_ONE;
                        out_r        <= end_bit(shift_word(shreg_r));
                        out_valid_r  <= 1'b1;
                        frame_last_r <= (cnt_r == CNT_PENULT);
                        if (accept_s) begin
                            pend_r      <= data_in;
                            pend_full_r <= 1'b1;
                        end else begin
                            pend_full_r <= pend_full_r;
                        end
                    end else if (pend_full_r) begin
                        shreg_r      <= pend_r;
                        pend_full_r  <= 1'b0;
                        cnt_r        <= CNT_ZERO;
                        out_r        <= end_bit(pend_r);
                        out_valid_r  <= 1'b1;
                        frame_last_r <= 1'b0;
                    end else if (accept_s) begin
                        // Bypass: the word offered on the last-bit edge follows with no gap.
                        shreg_r      <= data_in;
                        cnt_r        <= CNT_ZERO;
                        out_r        <= end_bit(data_in);
                        out_valid_r  <= 1'b1;
                        frame_last_r <= 1'b0;
                    end else begin
                        state_r      <= ST_IDLE;
                        cnt_r        <= CNT_ZERO;
                        out_r        <= IDLE_BIT;
                        out_valid_r  <= 1'b0;
                        frame_last_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= CNT_ZERO;
                    pend_full_r  <= 1'b0;
                    out_r        <= IDLE_BIT;
                    out_valid_r  <= 1'b0;
                    frame_last_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: the expected stream comes from a queue of pending
// output bits that advances one bit per clock and grows by a word per accept.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       R;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready, out, out_valid, frame_last;
    logic [7:0] data_in_l;
    logic       load_valid_l;
    logic       load_ready_l, out_l, out_valid_l, frame_last_l;

    int n_checks = 0;
    int n_fail   = 0;
    bit q[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .R(R), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .out(out), .out_valid(out_valid), .frame_last(frame_last)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
        .clk(clk), .R(R), .data_in(data_in_l), .load_valid(load_valid_l),
        .load_ready(load_ready_l), .out(out_l), .out_valid(out_valid_l), .frame_last(frame_last_l)
    );

    // One clock of the MSB-first DUT plus the reference model; exp = {out, out_valid, frame_last, load_ready}.
    task automatic drive_cycle(input logic v, input logic [7:0] d, output logic [3:0] exp);
        bit acc;
        acc = v && (q.size() <= 8);
        load_valid = v;
        data_in    = d;
        @(posedge clk);
        if (q.size() > 0) void'(q.pop_front());
        if (acc) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
        #1;
        exp[3] = (q.size() > 0) ? q[0] : 1'b0;
        exp[2] = (q.size() > 0);
        exp[1] = ((q.size() % 8) == 1);
        exp[0] = (q.size() <= 8);
    endtask

    task automatic test_reset();
        R = 1'b1; load_valid = 1'b0; data_in = 8'h00; load_valid_l = 1'b0; data_in_l = 8'h00;
        q.delete();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out, out_valid, frame_last, load_ready} !== 4'b0000) begin
                n_fail++; $display("FAIL reset_hold: got %b expected 0000", {out, out_valid, frame_last, load_ready});
            end
            n_checks++;
            if ({out_l, out_valid_l, load_ready_l} !== 3'b100) begin
                n_fail++; $display("FAIL reset_hold_lsb: got %b expected 100", {out_l, out_valid_l, load_ready_l});
            end
        end
        R = 1'b0; #1;
        n_checks++;
        if ({load_ready, out_valid, out} !== 3'b100) begin
            n_fail++; $display("FAIL reset_release: got %b expected 100", {load_ready, out_valid, out});
        end
    endtask

    task automatic test_single_word();
        logic [3:0] e; logic [7:0] bits, lasts; logic all_v;
        all_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(i == 0, (i == 0) ? 8'hB5 : 8'($urandom), e);
            n_checks++;
            if ({out, out_valid, frame_last, load_ready} !== e) begin
                n_fail++; $display("FAIL single_cycle%0d: got %b expected %b", i, {out, out_valid, frame_last, load_ready}, e);
            end
            bits[7-i] = out; lasts[7-i] = frame_last; all_v = all_v & out_valid;
        end
        drive_cycle(1'b0, 8'h00, e);
        n_checks++;
        if ({out, out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL single_after: got %b expected 00", {out, out_valid});
        end
        n_checks++;
        if (bits !== 8'b1011_0101) begin
            n_fail++; $display("FAIL single_bits: got %b expected 10110101", bits);
        end
        n_checks++;
        if ({lasts, all_v} !== {8'h01, 1'b1}) begin
            n_fail++; $display("FAIL single_flags: got last=%b valid=%b expected last=00000001 valid=1", lasts, all_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e; logic [15:0] bits, lasts, rdy;
        for (int i = 0; i < 17; i++) begin
            drive_cycle(i < 2, (i == 0) ? 8'hA5 : (i == 1) ? 8'h0F : 8'($urandom), e);
            n_checks++;
            if ({out, out_valid, frame_last, load_ready} !== e) begin
                n_fail++; $display("FAIL b2b_cycle%0d: got %b expected %b", i, {out, out_valid, frame_last, load_ready}, e);
            end
            if (i < 16) begin
                bits[15-i] = out & out_valid; lasts[15-i] = frame_last; rdy[15-i] = load_ready;
            end
        end
        n_checks++;
        if (bits !== 16'b1010_0101_0000_1111) begin
            n_fail++; $display("FAIL b2b_bits: got %b expected 1010010100001111", bits);
        end
        n_checks++;
        if (lasts !== 16'h0101) begin
            n_fail++; $display("FAIL b2b_last: got %b expected 0000000100000001", lasts);
        end
        n_checks++;
        if (rdy !== 16'h80FF) begin
            n_fail++; $display("FAIL b2b_ready: got %b expected 1000000011111111", rdy);
        end
    endtask

    task automatic test_bypass();
        logic [3:0] e; logic [15:0] bits; logic all_v;
        all_v = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_cycle((i == 0) || (i == 8), (i == 0) ? 8'h3C : (i == 8) ? 8'hC3 : 8'($urandom), e);
            n_checks++;
            if ({out, out_valid, frame_last, load_ready} !== e) begin
                n_fail++; $display("FAIL bypass_cycle%0d: got %b expected %b", i, {out, out_valid, frame_last, load_ready}, e);
            end
            if (i < 16) begin
                bits[15-i] = out; all_v = all_v & out_valid;
            end
        end
        n_checks++;
        if ({bits, all_v} !== {16'h3CC3, 1'b1}) begin
            n_fail++; $display("FAIL bypass_stream: got %h valid=%b expected 3cc3 valid=1", bits, all_v);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] e; logic [7:0] bits;
        drive_cycle(1'b1, 8'hFF, e);
        drive_cycle(1'b1, 8'h33, e);
        drive_cycle(1'b0, 8'h00, e);
        n_checks++;
        if ({out, out_valid, load_ready} !== 3'b110) begin
            n_fail++; $display("FAIL midrst_pre: got %b expected 110", {out, out_valid, load_ready});
        end
        #2; R = 1'b1; #1;
        n_checks++;
        if ({out, out_valid, frame_last, load_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_async: got %b expected 0000", {out, out_valid, frame_last, load_ready});
        end
        q.delete();
        @(posedge clk); #1; R = 1'b0; #1;
        n_checks++;
        if ({load_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL midrst_release: got %b expected 10", {load_ready, out_valid});
        end
        for (int i = 0; i < 9; i++) begin
            drive_cycle(i == 0, (i == 0) ? 8'h80 : 8'($urandom), e);
            n_checks++;
            if ({out, out_valid, frame_last, load_ready} !== e) begin
                n_fail++; $display("FAIL midrst_cycle%0d: got %b expected %b", i, {out, out_valid, frame_last, load_ready}, e);
            end
            if (i < 8) bits[7-i] = out;
        end
        n_checks++;
        if ({bits, out_valid} !== {8'h80, 1'b0}) begin
            n_fail++; $display("FAIL midrst_word: got %b valid=%b expected 10000000 valid=0", bits, out_valid);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w, bits, lasts; logic all_v;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8'h01 : 8'($urandom);
            all_v = 1'b1;
            load_valid_l = 1'b1; data_in_l = w;
            @(posedge clk); #1;
            load_valid_l = 1'b0; data_in_l = ~w;
            for (int i = 0; i < 8; i++) begin
                bits[i] = out_l; lasts[i] = frame_last_l; all_v = all_v & out_valid_l;
                @(posedge clk); #1;
            end
            n_checks++;
            if ({bits, lasts, all_v} !== {w, 8'h80, 1'b1}) begin
                n_fail++; $display("FAIL lsb_word%0d: got %b last=%b valid=%b expected %b last=10000000 valid=1", k, bits, lasts, all_v, w);
            end
            n_checks++;
            if ({out_l, out_valid_l} !== 2'b10) begin
                n_fail++; $display("FAIL lsb_idle%0d: got %b expected 10", k, {out_l, out_valid_l});
            end
        end
    endtask

    task automatic test_stream();
        logic [3:0] e; int lasts, valids;
        lasts = 0; valids = 0;
        for (int i = 0; i < 60; i++) begin
            drive_cycle(i < 40, 8'($urandom), e);
            n_checks++;
            if ({out, out_valid, frame_last, load_ready} !== e) begin
                n_fail++; $display("FAIL stream_cycle%0d: got %b expected %b", i, {out, out_valid, frame_last, load_ready}, e);
            end
            if (i < 40) begin
                lasts += int'(frame_last); valids += int'(out_valid);
            end
        end
        n_checks++;
        if (lasts != 5 || valids != 40) begin
            n_fail++; $display("FAIL stream_rate: got last=%0d valid=%0d expected last=5 valid=40", lasts, valids);
        end
    endtask

    task automatic test_random();
        logic [3:0] e;
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom % 4) != 0 && i < 380, 8'($urandom), e);
            n_checks++;
            if ({out, out_valid, frame_last, load_ready} !== e) begin
                n_fail++; $display("FAIL random_cycle%0d: got %b expected %b", i, {out, out_valid, frame_last, load_ready}, e);
            end
        end
    endtask

    // Overlapping "101" detector fed from the serial stream.
    task automatic test_detector();
        logic [3:0] e; logic [2:0] hist; logic [7:0] det; int pos;
        hist = 3'b000; det = 8'h00; pos = 0;
        for (int i = 0; i < 9; i++) begin
            drive_cycle(i == 0, (i == 0) ? 8'b0010_1010 : 8'($urandom), e);
            if (out_valid && pos < 8) begin
                hist = {hist[1:0], out};
                pos++;
                if (pos >= 3 && hist == 3'b101) det[pos-1] = 1'b1;
            end
        end
        n_checks++;
        if ({det, 4'(pos)} !== {8'b0101_0000, 4'd8}) begin
            n_fail++; $display("FAIL detector: got pulses=%b bits=%0d expected pulses=01010000 bits=8", det, pos);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bypass();
        test_reset_mid_word();
        test_lsb_first();
        test_stream();
        test_random();
        test_detector();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
